// File: rtl/mam_bb_arbiter_pkg.sv
// mam_bb_pkg: shared types for the N-port MAM Blackbone arbiter.
//   arb_state_e : arbiter FSM states
//   owner_id_t  : owner id, wide enough for the largest supported port count
//                 (ids 0..N_PORTS-1 are CPU ports, id N_PORTS is MAM)
//   mam_id()    : owner id used for MAM for a given port count
// No ports (package).
package mam_bb_pkg;

  localparam int MAX_PORTS = 8;
  localparam int OWNER_W   = $clog2(MAX_PORTS + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT_MAM = 2'd1,
    GRANT_CPU = 2'd2
  } arb_state_e;

  typedef logic [OWNER_W-1:0] owner_id_t;

  function automatic owner_id_t mam_id(input int n_ports);
    return owner_id_t'(n_ports);
  endfunction

endpackage

// File: rtl/mam_bb_arbiter_if.sv
// mam_bb_arbiter_if: all Blackbone bus signals around the arbiter.
//   CPU side : bb_in_addr_i/din_i/en_i/we_i (in), bb_in_gnt_o/dout_o/rvalid_o (out)
//   MAM side : bb_mam_addr_i/din_i/en_i/we_i (in), bb_mam_gnt_o/dout_o/rvalid_o (out)
//   Memory   : bb_out_addr_o/din_o/en_o/we_o (out), bb_out_dout_i (in)
// Modports: slave  = arbiter view (requests in, grants/memory port out)
//           master = requesters + memory view (the opposite directions)
interface mam_bb_arbiter_if #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int N_PORTS = 2
);
  logic [N_PORTS*AW-1:0] bb_in_addr_i;
  logic [N_PORTS*DW-1:0] bb_in_din_i;
  logic [N_PORTS-1:0]    bb_in_en_i;
  logic [N_PORTS-1:0]    bb_in_we_i;
  logic [N_PORTS-1:0]    bb_in_gnt_o;
  logic [N_PORTS*DW-1:0] bb_in_dout_o;
  logic [N_PORTS-1:0]    bb_in_rvalid_o;

  logic [AW-1:0]         bb_mam_addr_i;
  logic [DW-1:0]         bb_mam_din_i;
  logic                  bb_mam_en_i;
  logic                  bb_mam_we_i;
  logic                  bb_mam_gnt_o;
  logic [DW-1:0]         bb_mam_dout_o;
  logic                  bb_mam_rvalid_o;

  logic [AW-1:0]         bb_out_addr_o;
  logic [DW-1:0]         bb_out_din_o;
  logic                  bb_out_en_o;
  logic                  bb_out_we_o;
  logic [DW-1:0]         bb_out_dout_i;

  modport slave (
    input  bb_in_addr_i, bb_in_din_i, bb_in_en_i, bb_in_we_i,
    output bb_in_gnt_o, bb_in_dout_o, bb_in_rvalid_o,
    input  bb_mam_addr_i, bb_mam_din_i, bb_mam_en_i, bb_mam_we_i,
    output bb_mam_gnt_o, bb_mam_dout_o, bb_mam_rvalid_o,
    output bb_out_addr_o, bb_out_din_o, bb_out_en_o, bb_out_we_o,
    input  bb_out_dout_i
  );

  modport master (
    output bb_in_addr_i, bb_in_din_i, bb_in_en_i, bb_in_we_i,
    input  bb_in_gnt_o, bb_in_dout_o, bb_in_rvalid_o,
    output bb_mam_addr_i, bb_mam_din_i, bb_mam_en_i, bb_mam_we_i,
    input  bb_mam_gnt_o, bb_mam_dout_o, bb_mam_rvalid_o,
    input  bb_out_addr_o, bb_out_din_o, bb_out_en_o, bb_out_we_o,
    output bb_out_dout_i
  );
endinterface

// File: rtl/mam_bb_arbiter_rr_arb.sv
// mam_bb_rr_arb: combinational round-robin picker.
//   req   in  N_PORTS  request vector
//   ptr   in  owner id last granted index; search starts at ptr+1 (mod N_PORTS)
//   valid out 1        some request is set
//   idx   out owner id winning index
module mam_bb_rr_arb
  import mam_bb_pkg::*;
#(
  parameter int N_PORTS = 2
) (
  input  logic [N_PORTS-1:0] req,
  input  owner_id_t          ptr,
  output logic               valid,
  output owner_id_t          idx
);

  // Outer loop walks priority order; inner loop finds which port sits at
  // that position so every req[] index stays a loop constant.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (!valid && req[i] && (i == (int'(ptr) + k) % N_PORTS)) begin
          valid = 1'b1;
          idx   = owner_id_t'(i);
        end
      end
    end
  end

endmodule

// File: rtl/mam_bb_arbiter.sv
// mam_bb_arbiter: arbitrates N_PORTS CPU Blackbone ports plus one MAM port
// onto a single memory port. MAM has priority; CPUs share round-robin with
// a bounded hold time. Read data returns to the issuer after RD_LAT cycles.
// Ports:
//   bb_clk_i   in  clock
//   bb_rst_ni  in  asynchronous active-low reset
//   bus        mam_bb_arbiter_if.slave (CPU, MAM and memory signals)
// Option: define MAM_BB_ARB_PREEMPT_EN to let a MAM request force a CPU
// owner off immediately instead of waiting for release or hold expiry.
module mam_bb_arbiter
  import mam_bb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int N_PORTS  = 2,
  parameter int RD_LAT   = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic             bb_clk_i,
  input  logic             bb_rst_ni,
  mam_bb_arbiter_if.slave  bus
);

  localparam int        ID_W     = $clog2(N_PORTS + 1);
  localparam owner_id_t MAM_ID   = mam_id(N_PORTS);
  localparam int        HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit        HOLD_EN  = (MAX_HOLD != 0);

  arb_state_e          state_reg, state_next;
  owner_id_t           owner_reg, owner_next;
  owner_id_t           rr_ptr_reg, rr_ptr_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic                rd_valid_reg [RD_LAT];
  logic [ID_W-1:0]     rd_id_reg [RD_LAT];

  logic [N_PORTS-1:0]  owner_sel;
  logic [AW-1:0]       out_addr;
  logic [DW-1:0]       out_din;
  logic                out_en;
  logic                out_we;
  logic                others_pending;
  logic                hold_expired;
  logic                preempt;
  logic                force_off;
  logic                keep;
  logic                mam_ok;
  logic                rr_valid;
  owner_id_t           rr_idx;

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_sel
    assign owner_sel[gi] = (state_reg == GRANT_CPU) && (owner_reg == owner_id_t'(gi));
  end

  mam_bb_rr_arb #(.N_PORTS(N_PORTS)) u_rr (
    .req   (bus.bb_in_en_i),
    .ptr   (rr_ptr_reg),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

  // Memory port follows the current owner; out_en doubles as "owner still requests".
  always_comb begin
    out_addr = '0;
    out_din  = '0;
    out_en   = 1'b0;
    out_we   = 1'b0;
    if (state_reg == GRANT_MAM) begin
      out_addr = bus.bb_mam_addr_i;
      out_din  = bus.bb_mam_din_i;
      out_en   = bus.bb_mam_en_i;
      out_we   = bus.bb_mam_we_i;
    end else if (state_reg == GRANT_CPU) begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (owner_sel[i]) begin
          out_addr = bus.bb_in_addr_i[i*AW +: AW];
          out_din  = bus.bb_in_din_i[i*DW +: DW];
          out_en   = bus.bb_in_en_i[i];
          out_we   = bus.bb_in_we_i[i];
        end
      end
    end
  end

  assign others_pending = (state_reg == GRANT_MAM) ? (|bus.bb_in_en_i)
                        : (bus.bb_mam_en_i | (|(bus.bb_in_en_i & ~owner_sel)));
  assign hold_expired   = HOLD_EN && (hold_cnt_reg == HOLD_LIM) && others_pending;

`ifdef MAM_BB_ARB_PREEMPT_EN
  assign preempt = (state_reg == GRANT_CPU) && bus.bb_mam_en_i;
`else
  assign preempt = 1'b0;
`endif

  assign force_off = hold_expired | preempt;
  assign keep      = (state_reg != IDLE) && out_en && !force_off;
  // A MAM owner forced off by the hold limit must not immediately win again.
  assign mam_ok    = bus.bb_mam_en_i && !((state_reg == GRANT_MAM) && force_off);

  // A forced-off CPU owner sits at rr_ptr, so the rotation puts it last.
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    rr_ptr_next   = rr_ptr_reg;
    hold_cnt_next = hold_cnt_reg;
    if (keep) begin
      if (hold_cnt_reg != HOLD_LIM) begin
        hold_cnt_next = hold_cnt_reg + 1'b1;
      end
    end else begin
      hold_cnt_next = '0;
      if (mam_ok) begin
        state_next = GRANT_MAM;
        owner_next = MAM_ID;
      end else if (rr_valid) begin
        state_next  = GRANT_CPU;
        owner_next  = rr_idx;
        rr_ptr_next = rr_idx;
      end else begin
        state_next = IDLE;
        owner_next = '0;
      end
    end
  end

  always_ff @(posedge bb_clk_i or negedge bb_rst_ni) begin
    if (!bb_rst_ni) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      rr_ptr_reg   <= owner_id_t'(N_PORTS - 1);
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      rr_ptr_reg   <= rr_ptr_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Read return pipeline: records who issued each read, independent of
  // later grant changes.
  always_ff @(posedge bb_clk_i or negedge bb_rst_ni) begin
    if (!bb_rst_ni) begin
      for (int s = 0; s < RD_LAT; s++) begin
        rd_valid_reg[s] <= 1'b0;
        rd_id_reg[s]    <= '0;
      end
    end else begin
      rd_valid_reg[0] <= out_en & ~out_we;
      rd_id_reg[0]    <= ID_W'(owner_reg);
      for (int s = 1; s < RD_LAT; s++) begin
        rd_valid_reg[s] <= rd_valid_reg[s-1];
        rd_id_reg[s]    <= rd_id_reg[s-1];
      end
    end
  end

  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_ret
    assign bus.bb_in_rvalid_o[gi]       = rd_valid_reg[RD_LAT-1] && (rd_id_reg[RD_LAT-1] == ID_W'(gi));
    assign bus.bb_in_dout_o[gi*DW +: DW] = bus.bb_in_rvalid_o[gi] ? bus.bb_out_dout_i : '0;
  end

  assign bus.bb_mam_rvalid_o = rd_valid_reg[RD_LAT-1] && (rd_id_reg[RD_LAT-1] == ID_W'(N_PORTS));
  assign bus.bb_mam_dout_o   = bus.bb_mam_rvalid_o ? bus.bb_out_dout_i : '0;

  assign bus.bb_in_gnt_o   = owner_sel;
  assign bus.bb_mam_gnt_o  = (state_reg == GRANT_MAM);
  assign bus.bb_out_addr_o = out_addr;
  assign bus.bb_out_din_o  = out_din;
  assign bus.bb_out_en_o   = out_en;
  assign bus.bb_out_we_o   = out_we;

endmodule

// File: tb/tb_mam_bb_arbiter.sv
// tb_mam_bb_arbiter: directed checks of mam_bb_arbiter. Two instances share
// one stimulus: dut_a (RD_LAT=1, MAX_HOLD=4) and dut_b (RD_LAT=3, MAX_HOLD=2).
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge of the same cycle.
module tb_mam_bb_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NP = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NP*AW-1:0]  in_addr;
  logic [NP*DW-1:0]  in_din;
  logic [NP-1:0]     in_en;
  logic [NP-1:0]     in_we;
  logic [AW-1:0]     mam_addr;
  logic [DW-1:0]     mam_din;
  logic              mam_en;
  logic              mam_we;
  logic [DW-1:0]     mem_dout;

  int checks = 0;
  int errors = 0;

  mam_bb_arbiter_if #(.AW(AW), .DW(DW), .N_PORTS(NP)) ia ();
  mam_bb_arbiter_if #(.AW(AW), .DW(DW), .N_PORTS(NP)) ib ();

  assign ia.bb_in_addr_i  = in_addr;
  assign ia.bb_in_din_i   = in_din;
  assign ia.bb_in_en_i    = in_en;
  assign ia.bb_in_we_i    = in_we;
  assign ia.bb_mam_addr_i = mam_addr;
  assign ia.bb_mam_din_i  = mam_din;
  assign ia.bb_mam_en_i   = mam_en;
  assign ia.bb_mam_we_i   = mam_we;
  assign ia.bb_out_dout_i = mem_dout;

  assign ib.bb_in_addr_i  = in_addr;
  assign ib.bb_in_din_i   = in_din;
  assign ib.bb_in_en_i    = in_en;
  assign ib.bb_in_we_i    = in_we;
  assign ib.bb_mam_addr_i = mam_addr;
  assign ib.bb_mam_din_i  = mam_din;
  assign ib.bb_mam_en_i   = mam_en;
  assign ib.bb_mam_we_i   = mam_we;
  assign ib.bb_out_dout_i = mem_dout;

  mam_bb_arbiter #(.AW(AW), .DW(DW), .N_PORTS(NP), .RD_LAT(1), .MAX_HOLD(4)) dut_a (
    .bb_clk_i  (clk),
    .bb_rst_ni (rst_n),
    .bus       (ia)
  );

  mam_bb_arbiter #(.AW(AW), .DW(DW), .N_PORTS(NP), .RD_LAT(3), .MAX_HOLD(2)) dut_b (
    .bb_clk_i  (clk),
    .bb_rst_ni (rst_n),
    .bus       (ib)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_addr  = '0;
    in_din   = '0;
    in_en    = '0;
    in_we    = '0;
    mam_addr = '0;
    mam_din  = '0;
    mam_en   = 1'b0;
    mam_we   = 1'b0;
  endtask

  task automatic do_reset();
    next_cycle();
    rst_n = 1'b0;
    idle_inputs();
    next_cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    mem_dout = '0;
    idle_inputs();

    // Reset state
    sample();
    chk("rst_gnt_a",     64'(ia.bb_in_gnt_o), 64'h0);
    chk("rst_mgnt_a",    64'(ia.bb_mam_gnt_o), 64'h0);
    chk("rst_rvalid_b",  64'(ib.bb_in_rvalid_o), 64'h0);
    chk("rst_mrvalid_b", 64'(ib.bb_mam_rvalid_o), 64'h0);
    chk("rst_out_en_a",  64'(ia.bb_out_en_o), 64'h0);
    chk("rst_out_addr_a", 64'(ia.bb_out_addr_o), 64'h0);
    chk("rst_dout_a",    64'(ia.bb_in_dout_o), 64'h0);
    next_cycle();
    rst_n = 1'b1;

    // Single read by port 0
    in_en = 2'b01;
    in_we = 2'b00;
    in_addr[31:0] = 32'h10;
    sample();
    chk("t1_c0_gnt_a", 64'(ia.bb_in_gnt_o), 64'h0);
    chk("t1_c0_out_en_a", 64'(ia.bb_out_en_o), 64'h0);
    next_cycle();
    sample();
    chk("t1_c1_gnt_a", 64'(ia.bb_in_gnt_o), 64'h1);
    chk("t1_c1_out_addr_a", 64'(ia.bb_out_addr_o), 64'h10);
    chk("t1_c1_out_en_a", 64'(ia.bb_out_en_o), 64'h1);
    chk("t1_c1_out_we_a", 64'(ia.bb_out_we_o), 64'h0);
    next_cycle();
    in_en = 2'b00;
    mem_dout = 32'hA5A5A5A5;
    sample();
    chk("t1_c2_rvalid_a", 64'(ia.bb_in_rvalid_o), 64'h1);
    chk("t1_c2_dout0_a", 64'(ia.bb_in_dout_o[31:0]), 64'hA5A5A5A5);
    chk("t1_c2_dout1_a", 64'(ia.bb_in_dout_o[63:32]), 64'h0);
    chk("t1_c2_mrvalid_a", 64'(ia.bb_mam_rvalid_o), 64'h0);
    next_cycle();
    sample();
    chk("t1_c3_rvalid_a", 64'(ia.bb_in_rvalid_o), 64'h0);
    chk("t1_c3_gnt_a", 64'(ia.bb_in_gnt_o), 64'h0);
    next_cycle();
    sample();
    chk("t1_c4_rvalid_b", 64'(ib.bb_in_rvalid_o), 64'h1);
    chk("t1_c4_dout0_b", 64'(ib.bb_in_dout_o[31:0]), 64'hA5A5A5A5);

    // Two ports requesting continuously, hold limit 4 on dut_a
    do_reset();
    mem_dout = '0;
    in_en = 2'b11;
    in_we = 2'b11;
    in_addr = {32'h200, 32'h100};
    in_din  = {32'hBBBB0001, 32'hAAAA0001};
    for (int k = 1; k <= 12; k++) begin
      int p;
      next_cycle();
      sample();
      p = ((k - 1) / 4) % 2;
      chk($sformatf("t2_gnt_c%0d", k), 64'(ia.bb_in_gnt_o), 64'(1 << p));
      chk($sformatf("t2_out_en_c%0d", k), 64'(ia.bb_out_en_o), 64'h1);
      chk($sformatf("t2_out_addr_c%0d", k), 64'(ia.bb_out_addr_o),
          (p == 1) ? 64'h200 : 64'h100);
    end
    next_cycle();
    idle_inputs();

    // Port 1 owns, then MAM requests
    do_reset();
    in_en = 2'b10;
    in_we = 2'b10;
    in_addr = {32'h300, 32'h0};
    next_cycle();
    sample();
    chk("t3_c1_gnt_a", 64'(ia.bb_in_gnt_o), 64'h2);
    next_cycle();
    mam_en = 1'b1;
    mam_we = 1'b1;
    mam_addr = 32'h400;
    sample();
    chk("t3_c2_gnt_a", 64'(ia.bb_in_gnt_o), 64'h2);
    chk("t3_c2_mgnt_a", 64'(ia.bb_mam_gnt_o), 64'h0);
    next_cycle();
    in_en = 2'b00;
    sample();
`ifdef MAM_BB_ARB_PREEMPT_EN
    chk("t3_c3_gnt_a", 64'(ia.bb_in_gnt_o), 64'h0);
    chk("t3_c3_mgnt_a", 64'(ia.bb_mam_gnt_o), 64'h1);
`else
    chk("t3_c3_gnt_a", 64'(ia.bb_in_gnt_o), 64'h2);
    chk("t3_c3_mgnt_a", 64'(ia.bb_mam_gnt_o), 64'h0);
`endif
    next_cycle();
    sample();
    chk("t3_c4_gnt_a", 64'(ia.bb_in_gnt_o), 64'h0);
    chk("t3_c4_mgnt_a", 64'(ia.bb_mam_gnt_o), 64'h1);
    chk("t3_c4_out_addr_a", 64'(ia.bb_out_addr_o), 64'h400);
    chk("t3_c4_out_we_a", 64'(ia.bb_out_we_o), 64'h1);
    next_cycle();
    idle_inputs();

    // Port 0 reads then MAM read, RD_LAT=3 on dut_b
    do_reset();
    in_en = 2'b01;
    in_we = 2'b00;
    in_addr = {32'h0, 32'h20};
    next_cycle();
    sample();
    chk("t4_c1_gnt_b", 64'(ib.bb_in_gnt_o), 64'h1);
    next_cycle();
    mam_en = 1'b1;
    mam_we = 1'b0;
    mam_addr = 32'h40;
    sample();
    chk("t4_c2_gnt_b", 64'(ib.bb_in_gnt_o), 64'h1);
    chk("t4_c2_out_en_b", 64'(ib.bb_out_en_o), 64'h1);
    next_cycle();
    in_en = 2'b00;
    sample();
    chk("t4_c3_mgnt_b", 64'(ib.bb_mam_gnt_o), 64'h1);
    chk("t4_c3_gnt_b", 64'(ib.bb_in_gnt_o), 64'h0);
    chk("t4_c3_out_addr_b", 64'(ib.bb_out_addr_o), 64'h40);
    next_cycle();
    mam_en = 1'b0;
    mem_dout = 32'h11111111;
    sample();
    chk("t4_c4_rvalid_b", 64'(ib.bb_in_rvalid_o), 64'h1);
    chk("t4_c4_dout0_b", 64'(ib.bb_in_dout_o[31:0]), 64'h11111111);
    chk("t4_c4_mrvalid_b", 64'(ib.bb_mam_rvalid_o), 64'h0);
    next_cycle();
    mem_dout = 32'h22222222;
    sample();
    chk("t4_c5_rvalid_b", 64'(ib.bb_in_rvalid_o), 64'h1);
    chk("t4_c5_dout0_b", 64'(ib.bb_in_dout_o[31:0]), 64'h22222222);
    next_cycle();
    mem_dout = 32'h33333333;
    sample();
    chk("t4_c6_rvalid_b", 64'(ib.bb_in_rvalid_o), 64'h0);
    chk("t4_c6_mrvalid_b", 64'(ib.bb_mam_rvalid_o), 64'h1);
    chk("t4_c6_mdout_b", 64'(ib.bb_mam_dout_o), 64'h33333333);
    chk("t4_c6_dout0_b", 64'(ib.bb_in_dout_o[31:0]), 64'h0);
    next_cycle();
    sample();
    chk("t4_c7_mrvalid_b", 64'(ib.bb_mam_rvalid_o), 64'h0);
    chk("t4_c7_rvalid_b", 64'(ib.bb_in_rvalid_o), 64'h0);
    mem_dout = '0;

    // Lone requester is never forced off (MAX_HOLD=2 on dut_b)
    do_reset();
    in_en = 2'b10;
    in_we = 2'b10;
    in_addr = {32'h500, 32'h0};
    for (int k = 1; k <= 10; k++) begin
      next_cycle();
      sample();
      chk($sformatf("t5_gnt_b_c%0d", k), 64'(ib.bb_in_gnt_o), 64'h2);
    end
    next_cycle();
    idle_inputs();

    // Reset asserted while reads are in flight
    do_reset();
    in_en = 2'b01;
    in_we = 2'b00;
    in_addr = {32'h0, 32'h60};
    mem_dout = 32'h5A5A5A5A;
    next_cycle();
    next_cycle();
    #2;
    rst_n = 1'b0;
    sample();
    chk("t6_gnt_a", 64'(ia.bb_in_gnt_o), 64'h0);
    chk("t6_gnt_b", 64'(ib.bb_in_gnt_o), 64'h0);
    chk("t6_out_en_a", 64'(ia.bb_out_en_o), 64'h0);
    chk("t6_out_en_b", 64'(ib.bb_out_en_o), 64'h0);
    chk("t6_rvalid_a", 64'(ia.bb_in_rvalid_o), 64'h0);
    chk("t6_rvalid_b", 64'(ib.bb_in_rvalid_o), 64'h0);
    next_cycle();
    in_en = 2'b00;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("t6_post_rvalid_b_%0d", k), 64'(ib.bb_in_rvalid_o), 64'h0);
      chk($sformatf("t6_post_mrvalid_b_%0d", k), 64'(ib.bb_mam_rvalid_o), 64'h0);
      chk($sformatf("t6_post_rvalid_a_%0d", k), 64'(ia.bb_in_rvalid_o), 64'h0);
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
